// File: rtl/mp3_song_streamer_if.sv
// ROM read port plus the word stream toward the MP3 SPI serializer.
// The streamer drives the master side; ROM and serializer sit on slave.
interface mp3_song_streamer_if #(
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] ROM_ADDR;
   logic [31:0]       ROM_DATA;
   logic [31:0]       DATA_OUT;
   logic              DATA_VALID;
   logic              DATA_READY;

   modport master (
      output ROM_ADDR,
      output DATA_OUT,
      output DATA_VALID,
      input  ROM_DATA,
      input  DATA_READY
   );

   modport slave (
      input  ROM_ADDR,
      input  DATA_OUT,
      input  DATA_VALID,
      output ROM_DATA,
      output DATA_READY
   );
endinterface

// File: rtl/mp3_song_streamer.sv
// Fetches the selected song from ROM and streams it in DREQ-gated chunks.
// Optional MP3_STREAM_PAUSE_EN adds a PAUSE input holding off new chunks.
module mp3_song_streamer #(
   parameter int SONG_NUM    = 3,
   parameter int ADDR_W      = 16,
   parameter int SONG_WORDS  = 16384,
   parameter int CHUNK_WORDS = 8
) (
   input  logic              MP3_SCLK,
   input  logic              RESET,
   input  logic [31:0]       SongNow,
   input  logic              MP3_DREQ,
`ifdef MP3_STREAM_PAUSE_EN
   input  logic              PAUSE,
`endif
   output logic              SONG_START,
   output logic [ADDR_W-1:0] PLAY_POS,
   mp3_song_streamer_if.master bus
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WAIT_DREQ = 3'd1;
   localparam logic [2:0] FETCH     = 3'd2;
   localparam logic [2:0] LOAD      = 3'd3;
   localparam logic [2:0] SEND      = 3'd4;

   localparam int CW = $clog2(CHUNK_WORDS + 1);
   localparam logic [ADDR_W-1:0] LAST_POS =
      ADDR_W'(SONG_WORDS - 1);
   localparam logic [CW-1:0] LAST_WORD =
      CW'(CHUNK_WORDS - 1);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] cur_song_q, cur_song_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [31:0]       data_q, data_d;
   logic              valid_q, valid_d;
   logic              start_q, start_d;
   logic [ADDR_W-1:0] pos_q, pos_d;
   logic [CW-1:0]     chunk_q, chunk_d;

   logic [ADDR_W-1:0] sel;
   logic [ADDR_W-1:0] base;
   logic              change;
   logic              go;

   always_comb begin
      sel = '0;
      if (SongNow < 32'(SONG_NUM)) begin
         sel = SongNow[ADDR_W-1:0];
      end
   end

   assign base = ADDR_W'(32'(sel) * 32'(SONG_WORDS));

   assign change = (state_q != IDLE) &&
                   (sel != cur_song_q);

`ifdef MP3_STREAM_PAUSE_EN
   assign go = MP3_DREQ & ~PAUSE;
`else
   assign go = MP3_DREQ;
`endif

   always_comb begin
      state_d    = state_q;
      cur_song_d = cur_song_q;
      rom_addr_d = rom_addr_q;
      data_d     = data_q;
      valid_d    = valid_q;
      start_d    = 1'b0;
      pos_d      = pos_q;
      chunk_d    = chunk_q;

      unique case (state_q)
         IDLE: begin
            cur_song_d = sel;
            rom_addr_d = base;
            pos_d      = '0;
            start_d    = 1'b1;
            state_d    = WAIT_DREQ;
         end
         WAIT_DREQ: begin
            if (go) begin
               chunk_d = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            state_d = LOAD;
         end
         LOAD: begin
            data_d  = bus.ROM_DATA;
            valid_d = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (bus.DATA_READY) begin
               valid_d = 1'b0;
               chunk_d = chunk_q + 1'b1;
               if (pos_q == LAST_POS) begin
                  pos_d      = '0;
                  rom_addr_d = base;
               end else begin
                  pos_d      = pos_q + 1'b1;
                  rom_addr_d = rom_addr_q + 1'b1;
               end
               if (chunk_q == LAST_WORD) begin
                  state_d = WAIT_DREQ;
               end else begin
                  state_d = FETCH;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new song overrides everything, even a word mid-handshake.
      if (change) begin
         cur_song_d = sel;
         rom_addr_d = base;
         pos_d      = '0;
         chunk_d    = '0;
         valid_d    = 1'b0;
         start_d    = 1'b1;
         state_d    = WAIT_DREQ;
      end
   end

   always_ff @(posedge MP3_SCLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         cur_song_q <= '0;
         rom_addr_q <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         start_q    <= 1'b0;
         pos_q      <= '0;
         chunk_q    <= '0;
      end else begin
         state_q    <= state_d;
         cur_song_q <= cur_song_d;
         rom_addr_q <= rom_addr_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         start_q    <= start_d;
         pos_q      <= pos_d;
         chunk_q    <= chunk_d;
      end
   end

   assign bus.ROM_ADDR   = rom_addr_q;
   assign bus.DATA_OUT   = data_q;
   assign bus.DATA_VALID = valid_q;
   assign SONG_START     = start_q;
   assign PLAY_POS       = pos_q;

endmodule

// File: tb/tb_mp3_song_streamer.sv
// Bench for mp3_song_streamer: directed scenarios plus random traffic
// checked by a transaction-level scoreboard of the song word stream.
module tb_mp3_song_streamer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] song = 32'd0;
   logic        dreq = 1'b0;
   logic        ready = 1'b0;
`ifdef MP3_STREAM_PAUSE_EN
   logic        pause = 1'b0;
`endif
   logic        start1, start2;
   logic [15:0] pos1, pos2;

   int n_cmp = 0;
   int n_fail = 0;
   int sb_words = 0;

   mp3_song_streamer_if #(.ADDR_W(16)) b1 ();
   mp3_song_streamer_if #(.ADDR_W(16)) b2 ();

   mp3_song_streamer u_dut (
      .MP3_SCLK   (clk),
      .RESET      (rst),
      .SongNow    (song),
      .MP3_DREQ   (dreq),
`ifdef MP3_STREAM_PAUSE_EN
      .PAUSE      (pause),
`endif
      .SONG_START (start1),
      .PLAY_POS   (pos1),
      .bus        (b1)
   );

   mp3_song_streamer #(.SONG_WORDS(16)) u_dut_w (
      .MP3_SCLK   (clk),
      .RESET      (rst),
      .SongNow    (song),
      .MP3_DREQ   (dreq),
`ifdef MP3_STREAM_PAUSE_EN
      .PAUSE      (pause),
`endif
      .SONG_START (start2),
      .PLAY_POS   (pos2),
      .bus        (b2)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_f(input logic [15:0] a);
      return {a ^ 16'h3C5A, ~a};
   endfunction

   function automatic int base_of(input logic [31:0] s, input int sw);
      int sel;
      sel = (s < 32'd3) ? int'(s) : 0;
      return (sel * sw) % 65536;
   endfunction

   assign b1.DATA_READY = ready;
   assign b2.DATA_READY = ready;

   always @(posedge clk) begin
      b1.ROM_DATA <= rom_f(b1.ROM_ADDR);
      b2.ROM_DATA <= rom_f(b2.ROM_ADDR);
   end

   // Expected stream: word k of song s is ROM[base(s)+k mod SONG_WORDS].
   initial begin : scoreboard
      int m_base, m_pos;
      logic stall_p, rst_p;
      logic [31:0] data_p, exp;
      m_base = 0;
      m_pos = 0;
      stall_p = 1'b0;
      rst_p = 1'b1;
      data_p = '0;
      forever begin
         @(negedge clk);
         if (start1 === 1'b1) begin
            m_pos = 0;
            m_base = base_of(song, 16384);
         end
         if (!rst && !rst_p && stall_p && start1 !== 1'b1) begin
            n_cmp++;
            if (b1.DATA_VALID !== 1'b1 || b1.DATA_OUT !== data_p) begin
               n_fail++;
               $display("FAIL sb_hold: valid=%b data=%h want 1 %h",
                        b1.DATA_VALID, b1.DATA_OUT, data_p);
            end
         end
         if (b1.DATA_VALID === 1'b1 && ready) begin
            exp = rom_f(16'(m_base + m_pos));
            n_cmp++;
            if (b1.DATA_OUT !== exp || pos1 !== 16'(m_pos)) begin
               n_fail++;
               $display("FAIL sb_word: data=%h pos=%0d want %h %0d",
                        b1.DATA_OUT, pos1, exp, m_pos);
            end
            m_pos = (m_pos + 1) % 16384;
            sb_words++;
         end
         stall_p = (b1.DATA_VALID === 1'b1) && !ready;
         data_p = b1.DATA_OUT;
         rst_p = rst;
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({b1.ROM_ADDR, b1.DATA_OUT, b1.DATA_VALID, start1, pos1}
          !== '0) begin
         n_fail++;
         $display("FAIL reset_vals: addr=%h data=%h v=%b s=%b pos=%h want 0",
                  b1.ROM_ADDR, b1.DATA_OUT, b1.DATA_VALID, start1, pos1);
      end
      @(posedge clk); #1;
      song = 0; dreq = 1'b1; ready = 1'b1; rst = 1'b0;
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (start1 !== 1'b1 || b1.ROM_ADDR !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_start: start=%b addr=%h want 1 0",
                  start1, b1.ROM_ADDR);
      end
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (start1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pulse_len: start=%b want 0", start1);
      end
   endtask

   task automatic test_first_chunk();
      int cnt, cyc, t_first, t_last;
      logic seen;
      cnt = 0; cyc = 0; t_first = -1; t_last = -1;
      while (cnt < 8 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (b1.DATA_VALID === 1'b1 && t_first < 0) t_first = cyc;
         if (b1.DATA_VALID === 1'b1 && ready) begin
            cnt++;
            if (cnt == 8) t_last = cyc;
         end
      end
      n_cmp++;
      if (cnt != 8) begin
         n_fail++;
         $display("FAIL chunk1_words: got %0d want 8", cnt);
      end
      n_cmp++;
      if (t_last - t_first != 21) begin
         n_fail++;
         $display("FAIL chunk1_cycles: got %0d want 21", t_last - t_first);
      end
      @(posedge clk); #1;
      dreq = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (b1.DATA_VALID !== 1'b0) seen = 1'b1;
      end
      n_cmp++;
      if (seen || pos1 !== 16'd8 || b1.ROM_ADDR !== 16'd8) begin
         n_fail++;
         $display("FAIL chunk1_end: seen=%b pos=%0d addr=%0d want 0 8 8",
                  seen, pos1, b1.ROM_ADDR);
      end
   endtask

   task automatic test_dreq_gate();
      int cnt;
      logic [2:0] v;
      @(posedge clk); #1;
      song = 2;
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (start1 === 1'b1) cnt++;
      end
      n_cmp++;
      if (cnt != 1 || b1.ROM_ADDR !== 16'h8000 || pos1 !== 16'd0 ||
          b1.DATA_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL song2_restart: pulses=%0d addr=%h pos=%0d v=%b want 1 8000 0 0",
                  cnt, b1.ROM_ADDR, pos1, b1.DATA_VALID);
      end
      @(posedge clk); #1;
      dreq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); @(negedge clk);
         v[i] = b1.DATA_VALID;
      end
      n_cmp++;
      if (v !== 3'b100) begin
         n_fail++;
         $display("FAIL dreq_latency: valid seq=%b want 100", v);
      end
      n_cmp++;
      if (b1.DATA_OUT !== rom_f(16'h8000)) begin
         n_fail++;
         $display("FAIL song2_word0: got %h want %h",
                  b1.DATA_OUT, rom_f(16'h8000));
      end
   endtask

   task automatic test_dreq_drop();
      int cnt, cyc;
      logic seen;
      cyc = 0;
      cnt = (b1.DATA_VALID === 1'b1 && ready) ? 1 : 0;
      while (cnt < 2 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (b1.DATA_VALID === 1'b1 && ready) cnt++;
      end
      @(posedge clk); #1;
      dreq = 1'b0;
      while (cnt < 8 && cyc < 150) begin
         @(negedge clk);
         cyc++;
         if (b1.DATA_VALID === 1'b1 && ready) cnt++;
      end
      n_cmp++;
      if (cnt != 8) begin
         n_fail++;
         $display("FAIL dreq_drop_words: got %0d want 8", cnt);
      end
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (b1.DATA_VALID !== 1'b0) seen = 1'b1;
      end
      n_cmp++;
      if (seen || pos1 !== 16'd8) begin
         n_fail++;
         $display("FAIL dreq_drop_stall: seen=%b pos=%0d want 0 8",
                  seen, pos1);
      end
   endtask

   task automatic test_stall();
      int cyc;
      logic [31:0] d0;
      @(posedge clk); #1;
      ready = 1'b0; dreq = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (b1.DATA_VALID !== 1'b1 && cyc < 20);
      n_cmp++;
      if (b1.DATA_VALID !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_valid: valid=%b want 1", b1.DATA_VALID);
      end
      d0 = b1.DATA_OUT;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (b1.DATA_VALID !== 1'b1 || b1.DATA_OUT !== d0) begin
            n_fail++;
            $display("FAIL stall_hold%0d: v=%b data=%h want 1 %h",
                     i, b1.DATA_VALID, b1.DATA_OUT, d0);
         end
      end
      @(posedge clk); #1;
      ready = 1'b1; dreq = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (b1.DATA_VALID !== 1'b1 || b1.DATA_OUT !== rom_f(16'h8008)) begin
         n_fail++;
         $display("FAIL stall_accept: v=%b data=%h want 1 %h",
                  b1.DATA_VALID, b1.DATA_OUT, rom_f(16'h8008));
      end
      repeat (40) @(negedge clk);
      n_cmp++;
      if (pos1 !== 16'd16 || b1.DATA_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_chunk_end: pos=%0d v=%b want 16 0",
                  pos1, b1.DATA_VALID);
      end
   endtask

   task automatic test_song_change();
      int cyc;
      @(posedge clk); #1;
      song = 0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (b1.ROM_ADDR !== 16'd0 || pos1 !== 16'd0) begin
         n_fail++;
         $display("FAIL song0_restart: addr=%0d pos=%0d want 0 0",
                  b1.ROM_ADDR, pos1);
      end
      @(posedge clk); #1;
      dreq = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(pos1 === 16'd5 && b1.DATA_VALID === 1'b0) && cyc < 60);
      @(posedge clk); #1;
      ready = 1'b0;
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (b1.DATA_VALID !== 1'b1 || pos1 !== 16'd5) begin
         n_fail++;
         $display("FAIL change_setup: v=%b pos=%0d want 1 5",
                  b1.DATA_VALID, pos1);
      end
      @(posedge clk); #1;
      song = 1; dreq = 1'b0;
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (b1.DATA_VALID !== 1'b0 || start1 !== 1'b1 ||
          b1.ROM_ADDR !== 16'h4000 || pos1 !== 16'd0) begin
         n_fail++;
         $display("FAIL change_mid_send: v=%b s=%b addr=%h pos=%0d want 0 1 4000 0",
                  b1.DATA_VALID, start1, b1.ROM_ADDR, pos1);
      end
      @(negedge clk);
      n_cmp++;
      if (start1 !== 1'b0) begin
         n_fail++;
         $display("FAIL change_pulse_len: start=%b want 0", start1);
      end
      ready = 1'b1;
   endtask

   task automatic test_out_of_range();
      int cnt;
      @(posedge clk); #1;
      song = 7;
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (start1 !== 1'b1 || b1.ROM_ADDR !== 16'd0 || pos1 !== 16'd0 ||
          start2 !== 1'b1 || b2.ROM_ADDR !== 16'd0) begin
         n_fail++;
         $display("FAIL oor_restart: s=%b addr=%h pos=%0d s2=%b addr2=%h want 1 0 0 1 0",
                  start1, b1.ROM_ADDR, pos1, start2, b2.ROM_ADDR);
      end
      @(posedge clk); #1;
      song = 0;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (start1 !== 1'b0) cnt++;
      end
      n_cmp++;
      if (cnt != 0) begin
         n_fail++;
         $display("FAIL oor_alias: pulses=%0d want 0", cnt);
      end
   endtask

   task automatic test_wrap();
      int hs, cyc, starts;
      logic [15:0] p16, p17;
      logic [31:0] d16, d17;
      hs = 0; cyc = 0; starts = 0;
      p16 = 'x; p17 = 'x; d16 = 'x; d17 = 'x;
      @(posedge clk); #1;
      dreq = 1'b1; ready = 1'b1;
      while (hs < 17 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (start2 !== 1'b0) starts++;
         if (b2.DATA_VALID === 1'b1 && ready) begin
            hs++;
            if (hs == 16) begin p16 = pos2; d16 = b2.DATA_OUT; end
            if (hs == 17) begin p17 = pos2; d17 = b2.DATA_OUT; end
         end
      end
      n_cmp++;
      if (hs != 17 || starts != 0) begin
         n_fail++;
         $display("FAIL wrap_run: words=%0d pulses=%0d want 17 0", hs, starts);
      end
      n_cmp++;
      if (p16 !== 16'd15 || d16 !== rom_f(16'd15)) begin
         n_fail++;
         $display("FAIL wrap_last: pos=%0d data=%h want 15 %h",
                  p16, d16, rom_f(16'd15));
      end
      n_cmp++;
      if (p17 !== 16'd0 || d17 !== rom_f(16'd0)) begin
         n_fail++;
         $display("FAIL wrap_first: pos=%0d data=%h want 0 %h",
                  p17, d17, rom_f(16'd0));
      end
      @(posedge clk); #1;
      dreq = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int cyc;
      @(posedge clk); #1;
      dreq = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (b1.DATA_VALID !== 1'b1 && cyc < 20);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if ({b1.ROM_ADDR, b1.DATA_OUT, b1.DATA_VALID, start1, pos1}
          !== '0) begin
         n_fail++;
         $display("FAIL midreset_vals: addr=%h data=%h v=%b s=%b pos=%h want 0",
                  b1.ROM_ADDR, b1.DATA_OUT, b1.DATA_VALID, start1, pos1);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (start1 !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_start: start=%b want 1", start1);
      end
      @(posedge clk); #1;
      dreq = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   task automatic test_random();
      int gap, w0;
      gap = 0;
      w0 = sb_words;
      repeat (3000) begin
         @(posedge clk); #1;
         ready = ($urandom_range(0, 3) != 0);
         dreq = $urandom_range(0, 1) != 0;
         gap++;
         if (gap >= 6 && $urandom_range(0, 40) == 0) begin
            song = $urandom_range(0, 7);
            gap = 0;
         end
      end
      @(posedge clk); #1;
      dreq = 1'b0; ready = 1'b1;
      repeat (50) @(negedge clk);
      n_cmp++;
      if (sb_words - w0 < 50) begin
         n_fail++;
         $display("FAIL random_traffic: words=%0d want >=50", sb_words - w0);
      end
   endtask

`ifdef MP3_STREAM_PAUSE_EN
   task automatic test_pause();
      int cyc;
      logic seen;
      @(posedge clk); #1;
      pause = 1'b1; dreq = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (b1.DATA_VALID !== 1'b0) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
         n_fail++;
         $display("FAIL pause_hold: valid seen=%b want 0", seen);
      end
      @(posedge clk); #1;
      pause = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (b1.DATA_VALID !== 1'b1 && cyc < 8);
      n_cmp++;
      if (b1.DATA_VALID !== 1'b1) begin
         n_fail++;
         $display("FAIL pause_release: valid=%b want 1", b1.DATA_VALID);
      end
      @(posedge clk); #1;
      dreq = 1'b0;
      repeat (40) @(negedge clk);
   endtask
`endif

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_first_chunk();
      test_dreq_gate();
      test_dreq_drop();
      test_stall();
      test_song_change();
      test_out_of_range();
      test_wrap();
      test_reset_mid();
`ifdef MP3_STREAM_PAUSE_EN
      test_pause();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
